// File: rtl/ray_dispatcher.sv
// rtl/ray_dispatcher.sv - raster-order primary ray sequencing with RGB888 framebuffer writeback
// Optional frame statistics outputs are built when RAY_DISPATCH_STATS_EN is defined.
module ray_dispatcher #(
   parameter int WIDTH      = 1280,
   parameter int HEIGHT     = 720,
   parameter int CONTINUOUS = 0
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   output logic                                busy,
   output logic                                frame_done,
`ifdef RAY_DISPATCH_STATS_EN
   output logic [31:0]                         frame_cycles,
   output logic [15:0]                         max_ray_latency,
`endif
   output logic                                cam_req,
   output logic [10:0]                         cam_pixel_h,
   output logic [9:0]                          cam_pixel_v,
   input  logic                                cam_valid,
   input  logic [71:0]                         cam_ray_origin,
   input  logic [71:0]                         cam_ray_dir,
   output logic [71:0]                         ray_origin,
   output logic [71:0]                         ray_dir,
   output logic                                ray_valid,
   output logic [10:0]                         pixel_h_out,
   output logic [9:0]                          pixel_v_out,
   input  logic                                ray_done,
   input  logic [71:0]                         pixel_color,
   output logic                                fb_we,
   output logic [$clog2(WIDTH*HEIGHT)-1:0]     fb_addr,
   output logic [23:0]                         fb_data,
   input  logic                                fb_ready
);

   localparam int AW = $clog2(WIDTH*HEIGHT);
   localparam logic [10:0] H_LAST = 11'(WIDTH - 1);
   localparam logic [9:0]  V_LAST = 10'(HEIGHT - 1);

   typedef enum logic [2:0] {S_IDLE, S_GEN, S_ISSUE, S_WAIT, S_WRITE} state_t;

   state_t        state_q, state_d;
   logic [10:0]   h_q, h_d;
   logic [9:0]    v_q, v_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          cam_req_q, cam_req_d;
   logic          ray_valid_q, ray_valid_d;
   logic [71:0]   org_q, org_d;
   logic [71:0]   dir_q, dir_d;
   logic          fb_we_q, fb_we_d;
   logic [AW-1:0] fb_addr_q, fb_addr_d;
   logic [23:0]   fb_data_q, fb_data_d;

   // fp24 channel to 8-bit unsigned: negatives and values below 1/256 go to 0, >= 1.0 clamps.
   function automatic logic [7:0] fp24_to_u8(input logic [23:0] c);
      logic [16:0] shifted;
      if (c[23] || c[22:16] < 7'd55) begin
         return 8'd0;
      end else if (c[22:16] >= 7'd63) begin
         return 8'hFF;
      end else begin
         shifted = {1'b1, c[15:0]} >> (7'd71 - c[22:16]);
         return shifted[7:0];
      end
   endfunction

   always_comb begin
      state_d     = state_q;
      h_d         = h_q;
      v_d         = v_q;
      addr_d      = addr_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      cam_req_d   = cam_req_q;
      ray_valid_d = 1'b0;
      org_d       = org_q;
      dir_d       = dir_q;
      fb_we_d     = fb_we_q;
      fb_addr_d   = fb_addr_q;
      fb_data_d   = fb_data_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               h_d       = '0;
               v_d       = '0;
               addr_d    = '0;
               busy_d    = 1'b1;
               cam_req_d = 1'b1;
               state_d   = S_GEN;
            end
         end
         S_GEN: begin
            if (cam_valid && cam_req_q) begin
               org_d       = cam_ray_origin;
               dir_d       = cam_ray_dir;
               cam_req_d   = 1'b0;
               ray_valid_d = 1'b1;
               state_d     = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (ray_done) begin
               fb_data_d = {fp24_to_u8(pixel_color[71:48]),
                            fp24_to_u8(pixel_color[47:24]),
                            fp24_to_u8(pixel_color[23:0])};
               fb_addr_d = addr_q;
               fb_we_d   = 1'b1;
               state_d   = S_WRITE;
            end
         end
         S_WRITE: begin
            if (fb_ready) begin
               fb_we_d = 1'b0;
               if (h_q == H_LAST && v_q == V_LAST) begin
                  h_d    = '0;
                  v_d    = '0;
                  addr_d = '0;
                  done_d = 1'b1;
                  if (CONTINUOUS != 0) begin
                     cam_req_d = 1'b1;
                     state_d   = S_GEN;
                  end else begin
                     busy_d  = 1'b0;
                     state_d = S_IDLE;
                  end
               end else begin
                  if (h_q == H_LAST) begin
                     h_d = '0;
                     v_d = v_q + 10'd1;
                  end else begin
                     h_d = h_q + 11'd1;
                  end
                  addr_d    = addr_q + AW'(1);
                  cam_req_d = 1'b1;
                  state_d   = S_GEN;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         h_q         <= '0;
         v_q         <= '0;
         addr_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cam_req_q   <= 1'b0;
         ray_valid_q <= 1'b0;
         org_q       <= '0;
         dir_q       <= '0;
         fb_we_q     <= 1'b0;
         fb_addr_q   <= '0;
         fb_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         h_q         <= h_d;
         v_q         <= v_d;
         addr_q      <= addr_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         cam_req_q   <= cam_req_d;
         ray_valid_q <= ray_valid_d;
         org_q       <= org_d;
         dir_q       <= dir_d;
         fb_we_q     <= fb_we_d;
         fb_addr_q   <= fb_addr_d;
         fb_data_q   <= fb_data_d;
      end
   end

`ifdef RAY_DISPATCH_STATS_EN
   logic [31:0] cyc_q, frame_cycles_q;
   logic [15:0] lat_q, max_lat_q;
   logic        frame_start;

   assign frame_start = (state_q == S_IDLE && start) || (done_d && CONTINUOUS != 0);

   // Latency counts from the launch cycle, so a ray_done on the first WAIT cycle reads as 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_q          <= '0;
         frame_cycles_q <= '0;
         lat_q          <= '0;
         max_lat_q      <= '0;
      end else begin
         if (frame_start) begin
            cyc_q     <= '0;
            max_lat_q <= '0;
         end else if (busy_q) begin
            cyc_q <= cyc_q + 32'd1;
         end
         if (done_d) begin
            frame_cycles_q <= cyc_q + 32'd1;
         end
         if (state_q == S_ISSUE) begin
            lat_q <= 16'd1;
         end else if (state_q == S_WAIT && lat_q != 16'hFFFF) begin
            lat_q <= lat_q + 16'd1;
         end
         if (state_q == S_WAIT && ray_done && lat_q > max_lat_q) begin
            max_lat_q <= lat_q;
         end
      end
   end

   assign frame_cycles    = frame_cycles_q;
   assign max_ray_latency = max_lat_q;
`else
   // Statistics counters are not built in this configuration.
`endif

   assign busy        = busy_q;
   assign frame_done  = done_q;
   assign cam_req     = cam_req_q;
   assign cam_pixel_h = h_q;
   assign cam_pixel_v = v_q;
   assign ray_origin  = org_q;
   assign ray_dir     = dir_q;
   assign ray_valid   = ray_valid_q;
   assign pixel_h_out = h_q;
   assign pixel_v_out = v_q;
   assign fb_we       = fb_we_q;
   assign fb_addr     = fb_addr_q;
   assign fb_data     = fb_data_q;

endmodule

// File: tb/tb_ray_dispatcher.sv
// tb/tb_ray_dispatcher.sv - randomized self-checking bench for ray_dispatcher against a pixel-level model
module tb_ray_dispatcher;
   localparam int W   = 4;
   localparam int H   = 2;
   localparam int AW  = $clog2(W*H);
   localparam int WC  = 2;
   localparam int HC  = 2;
   localparam int AWC = $clog2(WC*HC);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b1;
   logic          start = 1'b0, cam_valid = 1'b0, ray_done = 1'b0, fb_ready = 1'b1;
   logic [71:0]   cam_ray_origin = '0, cam_ray_dir = '0, pixel_color = '0;
   logic          busy, frame_done, cam_req, ray_valid, fb_we;
   logic [10:0]   cam_pixel_h, pixel_h_out;
   logic [9:0]    cam_pixel_v, pixel_v_out;
   logic [71:0]   ray_origin, ray_dir;
   logic [AW-1:0] fb_addr;
   logic [23:0]   fb_data;

   logic           start_c = 1'b0, cam_valid_c = 1'b0, ray_done_c = 1'b0, fb_ready_c = 1'b1;
   logic [71:0]    cam_org_c = '0, cam_dir_c = '0, pixel_color_c = '0;
   logic           busy_c, frame_done_c, cam_req_c, ray_valid_c, fb_we_c;
   logic [10:0]    cam_pixel_h_c, pixel_h_out_c;
   logic [9:0]     cam_pixel_v_c, pixel_v_out_c;
   logic [71:0]    ray_origin_c, ray_dir_c;
   logic [AWC-1:0] fb_addr_c;
   logic [23:0]    fb_data_c;

   ray_dispatcher #(.WIDTH(W), .HEIGHT(H), .CONTINUOUS(0)) u_dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .frame_done(frame_done),
      .cam_req(cam_req), .cam_pixel_h(cam_pixel_h), .cam_pixel_v(cam_pixel_v),
      .cam_valid(cam_valid), .cam_ray_origin(cam_ray_origin), .cam_ray_dir(cam_ray_dir),
      .ray_origin(ray_origin), .ray_dir(ray_dir), .ray_valid(ray_valid),
      .pixel_h_out(pixel_h_out), .pixel_v_out(pixel_v_out), .ray_done(ray_done),
      .pixel_color(pixel_color), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
      .fb_ready(fb_ready)
   );

   ray_dispatcher #(.WIDTH(WC), .HEIGHT(HC), .CONTINUOUS(1)) u_dut_c (
      .clk(clk), .rst(rst), .start(start_c), .busy(busy_c), .frame_done(frame_done_c),
      .cam_req(cam_req_c), .cam_pixel_h(cam_pixel_h_c), .cam_pixel_v(cam_pixel_v_c),
      .cam_valid(cam_valid_c), .cam_ray_origin(cam_org_c), .cam_ray_dir(cam_dir_c),
      .ray_origin(ray_origin_c), .ray_dir(ray_dir_c), .ray_valid(ray_valid_c),
      .pixel_h_out(pixel_h_out_c), .pixel_v_out(pixel_v_out_c), .ray_done(ray_done_c),
      .pixel_color(pixel_color_c), .fb_we(fb_we_c), .fb_addr(fb_addr_c), .fb_data(fb_data_c),
      .fb_ready(fb_ready_c)
   );

   int n_checks = 0;
   int n_errors = 0;
   int n_writes = 0, n_launch = 0, n_done = 0;
   logic prev_we = 1'b0;

   task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // An accepted write always ends with fb_we dropping, so falling edges count writes.
   always @(negedge clk) begin
      if (prev_we && !fb_we) n_writes++;
      if (ray_valid) n_launch++;
      if (frame_done) n_done++;
      prev_we = fb_we;
   end

   // Real-valued reference: value * 256, truncated, clamped to 255; negatives are black.
   function automatic logic [7:0] ref_u8(input logic [23:0] c);
      real val;
      int  e;
      if (c[23]) return 8'd0;
      e   = int'(c[22:16]);
      val = (2.0 ** (e - 63)) * (1.0 + real'(c[15:0]) / 65536.0) * 256.0;
      if (val >= 255.0) return 8'd255;
      return 8'($rtoi(val));
   endfunction

   function automatic logic [71:0] rand72();
      logic [95:0] r;
      r = {$urandom(), $urandom(), $urandom()};
      return r[71:0];
   endfunction

   function automatic logic [23:0] rand_chan();
      logic       s;
      logic [6:0] e;
      s = ($urandom_range(0, 7) == 0);
      e = 7'($urandom_range(50, 66));
      return {s, e, 16'($urandom())};
   endfunction

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_ctrl"}, {busy, frame_done, cam_req, ray_valid, fb_we}, 0);
      check_eq({tag, "_pix"}, {cam_pixel_h, cam_pixel_v, pixel_h_out, pixel_v_out}, 0);
      check_eq({tag, "_org"}, ray_origin, 0);
      check_eq({tag, "_dir"}, ray_dir, 0);
      check_eq({tag, "_fb"}, {fb_addr, fb_data}, 0);
   endtask

   task automatic serve_pixel(input int h, input int v, input logic [71:0] col, input int lat,
                              input int stall, input bit ghost, input bit start_in_wait,
                              input bit reset_in_wait, input bit last,
                              output logic [23:0] seen_data);
      int          n;
      int          nh, nv;
      logic [71:0] org, dir;
      logic [23:0] exp_data;
      seen_data = '0;
      n = 0;
      while (!cam_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_eq("cam_req", cam_req, 1);
      check_eq("cam_h", cam_pixel_h, h);
      check_eq("cam_v", cam_pixel_v, v);
      check_eq("gen_no_launch", ray_valid, 0);
      if (ghost) begin
         ray_done = 1'b1;
         pixel_color = rand72();
         @(negedge clk);
         ray_done = 1'b0;
         check_eq("ghost_no_write", fb_we, 0);
         check_eq("ghost_still_req", cam_req, 1);
      end
      org = rand72();
      dir = rand72();
      cam_ray_origin = org;
      cam_ray_dir = dir;
      cam_valid = 1'b1;
      @(negedge clk);
      cam_valid = 1'b0;
      cam_ray_origin = rand72();
      cam_ray_dir = rand72();
      check_eq("launch", ray_valid, 1);
      check_eq("cam_req_drop", cam_req, 0);
      check_eq("ray_origin", ray_origin, org);
      check_eq("ray_dir", ray_dir, dir);
      check_eq("pix_hv", {pixel_h_out, pixel_v_out}, {11'(h), 10'(v)});
      @(negedge clk);
      check_eq("launch_pulse", ray_valid, 0);
      if (reset_in_wait) begin
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         check_all_zero("mid_rst");
         return;
      end
      for (int i = 1; i < lat; i++) begin
         start = (start_in_wait && i == 1);
         @(negedge clk);
      end
      start = 1'b0;
      check_eq("hold_org", ray_origin, org);
      check_eq("hold_pix", {pixel_h_out, pixel_v_out}, {11'(h), 10'(v)});
      check_eq("wait_busy", busy, 1);
      check_eq("wait_no_req", cam_req, 0);
      ray_done = 1'b1;
      pixel_color = col;
      @(negedge clk);
      ray_done = 1'b0;
      pixel_color = rand72();
      exp_data = {ref_u8(col[71:48]), ref_u8(col[47:24]), ref_u8(col[23:0])};
      seen_data = fb_data;
      check_eq("fb_we", fb_we, 1);
      check_eq("fb_addr", fb_addr, v * W + h);
      check_eq("fb_data", fb_data, exp_data);
      if (stall > 0) begin
         fb_ready = 1'b0;
         for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check_eq("stall_fb", {fb_we, fb_addr, fb_data}, {1'b1, AW'(v * W + h), exp_data});
            check_eq("stall_quiet", {cam_req, ray_valid}, 0);
            check_eq("stall_pix", {pixel_h_out, pixel_v_out}, {11'(h), 10'(v)});
         end
         fb_ready = 1'b1;
      end
      @(negedge clk);
      nh = last ? 0 : (h == W - 1 ? 0 : h + 1);
      nv = last ? 0 : (h == W - 1 ? v + 1 : v);
      check_eq("we_drop", fb_we, 0);
      check_eq("frame_done", frame_done, last);
      check_eq("busy_after", busy, !last);
      check_eq("next_pix", {pixel_h_out, pixel_v_out}, {11'(nh), 10'(nv)});
   endtask

   task automatic run_frame(input bit directed, input bit special);
      int          w0, l0, d0;
      int          lat;
      logic [71:0] col;
      logic [23:0] seen;
      w0 = n_writes;
      l0 = n_launch;
      d0 = n_done;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_eq("start_busy", busy, 1);
      for (int p = 0; p < W * H; p++) begin
         col = {rand_chan(), rand_chan(), rand_chan()};
         if (directed && p == 0) col = {24'h3F0000, 24'h3E0000, 24'hBF0000};
         if (directed && p == 1) col = {24'h370000, 24'h3E8000, 24'h360000};
         lat = (directed || special) ? 5 : $urandom_range(1, 6);
         serve_pixel(p % W, p / W, col, lat, (special && p == 2) ? 10 : 0,
                     special && p == 3, special && p == 4, 1'b0, p == W * H - 1, seen);
         if (directed && p == 0) check_eq("conv_clamp", seen, 24'hFF8000);
         if (directed && p == 1) check_eq("conv_small", seen, 24'h01C000);
      end
      repeat (3) @(negedge clk);
      check_eq("frame_writes", n_writes - w0, W * H);
      check_eq("frame_launches", n_launch - l0, W * H);
      check_eq("frame_done_cnt", n_done - d0, 1);
      check_eq("idle_after", {busy, cam_req}, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      logic [23:0] seen;
      int          n;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_all_zero("reset");

      run_frame(1'b1, 1'b0);
      run_frame(1'b0, 1'b1);
      for (int k = 0; k < 3; k++) run_frame(1'b0, 1'b0);

      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int p = 0; p < 5; p++)
         serve_pixel(p % W, p / W, {rand_chan(), rand_chan(), rand_chan()}, 2, 0, 0, 0, 0, 0, seen);
      serve_pixel(1, 1, '0, 2, 0, 0, 0, 1'b1, 0, seen);
      repeat (3) @(negedge clk);
      check_eq("post_rst_idle", {busy, cam_req, fb_we}, 0);
      run_frame(1'b0, 1'b0);

      start_c = 1'b1;
      @(negedge clk);
      start_c = 1'b0;
      for (int p = 0; p < WC * HC; p++) begin
         n = 0;
         while (!cam_req_c && n < 20) begin
            @(negedge clk);
            n++;
         end
         check_eq("c_cam_req", cam_req_c, 1);
         check_eq("c_cam_pix", {cam_pixel_h_c, cam_pixel_v_c}, {11'(p % WC), 10'(p / WC)});
         cam_org_c = rand72();
         cam_valid_c = 1'b1;
         @(negedge clk);
         cam_valid_c = 1'b0;
         check_eq("c_launch", ray_valid_c, 1);
         check_eq("c_org", ray_origin_c, cam_org_c);
         repeat (2) @(negedge clk);
         ray_done_c = 1'b1;
         pixel_color_c = {24'h3F0000, 24'h000000, 24'h3E0000};
         @(negedge clk);
         ray_done_c = 1'b0;
         check_eq("c_fb", {fb_we_c, fb_addr_c, fb_data_c}, {1'b1, AWC'(p), 24'hFF0080});
         @(negedge clk);
         check_eq("c_done", frame_done_c, p == WC * HC - 1);
         check_eq("c_busy", busy_c, 1);
      end
      check_eq("c_restart_req", cam_req_c, 1);
      check_eq("c_restart_pix", {cam_pixel_h_c, cam_pixel_v_c}, 0);
      @(negedge clk);
      check_eq("c_done_pulse", frame_done_c, 0);
      check_eq("c_still_busy", busy_c, 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
